// File: rtl/alu_issue.sv
// alu_issue: decodes RV32I OP / OP-IMM / BRANCH instructions into ALU control,
// then runs a two-stage valid/ready pipeline: issue register (S1) and result register (S2).
package alu_issue_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_control_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
endpackage

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [N-1:0]     in_rs1,
  input  logic [N-1:0]     in_rs2,
  input  logic [N-1:0]     in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_taken,
  output logic             out_is_branch,
  output logic             out_overflow,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       illegal_count
);

  alu_control_t dec_ctrl;
  logic [N-1:0] dec_b;
  logic         dec_branch, dec_illegal, f7_ok, f7_alt;

  logic             s1_valid, s1_branch, s1_illegal;
  alu_control_t     s1_ctrl;
  logic [N-1:0]     s1_a, s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic [2:0]       s1_f3;

  logic [N-1:0] alu_res, alu_sum, alu_diff;
  logic         alu_ovf, alu_taken, alu_equal;
  logic [4:0]   shamt;
  logic         s2_adv, accept, xfer;

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;
  assign accept   = in_valid & in_ready;
  assign xfer     = s1_valid & s2_adv;

  // Instruction decode; illegal encodings fall back to ADD and are squashed at S2.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_b       = in_rs2;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    f7_ok       = (in_funct7 == 7'h00) || (in_funct7 == 7'h20);
    f7_alt      = (in_funct7 == 7'h20);
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: begin
        if (in_opcode == OPC_OP_IMM) dec_b = in_imm;
        case (in_funct3)
          3'b000:  dec_ctrl = (in_opcode == OPC_OP && f7_alt) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_ctrl = ALU_SLL;
          3'b010:  dec_ctrl = ALU_SLT;
          3'b011:  dec_ctrl = ALU_SLTU;
          3'b100:  dec_ctrl = ALU_XOR;
          3'b101:  dec_ctrl = f7_alt ? ALU_SRA : ALU_SRL;
          3'b110:  dec_ctrl = ALU_OR;
          default: dec_ctrl = ALU_AND;
        endcase
        // OP-IMM only constrains imm[11:5] for shifts; OP constrains funct7 everywhere.
        if (in_opcode == OPC_OP)
          dec_illegal = !f7_ok || (f7_alt && in_funct3 != 3'b000 && in_funct3 != 3'b101);
        else if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          dec_illegal = !f7_ok || (f7_alt && in_funct3 != 3'b101);
      end
      OPC_BRANCH: begin
        dec_branch = 1'b1;
        case (in_funct3)
          3'b000, 3'b001: dec_ctrl = ALU_SUB;
          3'b100, 3'b101: dec_ctrl = ALU_SLT;
          3'b110, 3'b111: dec_ctrl = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec_ctrl = ALU_ADD;
  end

  // S1: issue register, loaded on accept and drained by the S1->S2 transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_ctrl    <= ALU_ADD;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      s1_branch  <= 1'b0;
      s1_illegal <= 1'b0;
      s1_f3      <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_ctrl    <= dec_ctrl;
      s1_a       <= in_rs1;
      s1_b       <= dec_b;
      s1_tag     <= in_tag;
      s1_branch  <= dec_branch;
      s1_illegal <= dec_illegal;
      s1_f3      <= in_funct3;
    end else if (xfer) begin
      s1_valid   <= 1'b0;
    end
  end

  // ALU and branch resolution on the S1 operands.
  always_comb begin
    shamt     = s1_b[4:0];
    alu_sum   = s1_a + s1_b;
    alu_diff  = s1_a - s1_b;
    alu_equal = (s1_a == s1_b);
    alu_ovf   = 1'b0;
    alu_res   = '0;
    alu_taken = 1'b0;
    case (s1_ctrl)
      ALU_ADD: begin
        alu_res = alu_sum;
        alu_ovf = (s1_a[N-1] == s1_b[N-1]) && (alu_sum[N-1] != s1_a[N-1]);
      end
      ALU_SUB: begin
        alu_res = alu_diff;
        alu_ovf = (s1_a[N-1] != s1_b[N-1]) && (alu_diff[N-1] != s1_a[N-1]);
      end
      ALU_SLL:  alu_res = s1_a << shamt;
      ALU_SLT:  alu_res = {{(N-1){1'b0}}, $signed(s1_a) < $signed(s1_b)};
      ALU_SLTU: alu_res = {{(N-1){1'b0}}, s1_a < s1_b};
      ALU_XOR:  alu_res = s1_a ^ s1_b;
      ALU_SRL:  alu_res = s1_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(s1_a) >>> shamt);
      ALU_OR:   alu_res = s1_a | s1_b;
      default:  alu_res = s1_a & s1_b;
    endcase
    if (s1_branch) begin
      case (s1_f3)
        3'b000:         alu_taken = alu_equal;
        3'b001:         alu_taken = ~alu_equal;
        3'b100, 3'b110: alu_taken = alu_res[0];
        3'b101, 3'b111: alu_taken = ~alu_res[0];
        default:        alu_taken = 1'b0;
      endcase
    end
    if (s1_illegal) begin
      alu_res   = '0;
      alu_ovf   = 1'b0;
      alu_taken = 1'b0;
    end
  end

  // S2: output register; data holds while waiting for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_taken     <= 1'b0;
      out_is_branch <= 1'b0;
      out_overflow  <= 1'b0;
      out_zero      <= 1'b0;
      out_illegal   <= 1'b0;
      out_tag       <= '0;
      illegal_count <= '0;
    end else if (xfer) begin
      out_valid     <= 1'b1;
      out_result    <= alu_res;
      out_taken     <= alu_taken;
      out_is_branch <= s1_branch;
      out_overflow  <= alu_ovf;
      out_zero      <= (alu_res == '0);
      out_illegal   <= s1_illegal;
      out_tag       <= s1_tag;
      if (s1_illegal && illegal_count != 8'hFF) illegal_count <= illegal_count + 8'd1;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboarded random + directed bench for alu_issue against an arithmetic reference model.
module tb_alu_issue;
  typedef struct packed {
    logic [31:0] result;
    logic        taken;
    logic        is_branch;
    logic        ovf;
    logic        zero;
    logic        illegal;
    logic [4:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [4:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_taken, out_is_branch, out_overflow, out_zero, out_illegal;
  logic [4:0]  out_tag;
  logic [7:0]  illegal_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ill_model = 0;
  int   rdy_mode = 1;
  logic bp_done;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_taken(out_taken), .out_is_branch(out_is_branch),
    .out_overflow(out_overflow), .out_zero(out_zero), .out_illegal(out_illegal),
    .out_tag(out_tag), .illegal_count(illegal_count)
  );

  function automatic exp_t mk(logic [31:0] r, logic t, logic b, logic o, logic z, logic i, logic [4:0] g);
    exp_t e;
    e.result = r; e.taken = t; e.is_branch = b; e.ovf = o; e.zero = z; e.illegal = i; e.tag = g;
    return e;
  endfunction

  function automatic exp_t cur_out();
    return mk(out_result, out_taken, out_is_branch, out_overflow, out_zero, out_illegal, out_tag);
  endfunction

  function automatic logic ovf32(longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference: RV32I semantics computed with plain signed/unsigned arithmetic.
  function automatic exp_t model(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                 logic [31:0] a, logic [31:0] rs2, logic [31:0] imm, logic [4:0] tag);
    exp_t   e;
    logic [31:0] b;
    longint s;
    logic   lt, ltu, legal;
    e = '0;
    e.tag = tag;
    e.is_branch = (op == 7'h63);
    legal = 1'b1;
    b   = (op == 7'h13) ? imm : rs2;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h33) legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      else if (f3 == 3'd1 || f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
      case (f3)
        3'd0: begin
          if (op == 7'h33 && f7 == 7'h20) s = longint'($signed(a)) - longint'($signed(b));
          else s = longint'($signed(a)) + longint'($signed(b));
          e.result = s[31:0];
          e.ovf = ovf32(s);
        end
        3'd1: e.result = a << b[4:0];
        3'd2: e.result = 32'(lt);
        3'd3: e.result = 32'(ltu);
        3'd4: e.result = a ^ b;
        3'd5: if (f7 == 7'h20) e.result = $signed(a) >>> b[4:0]; else e.result = a >> b[4:0];
        3'd6: e.result = a | b;
        default: e.result = a & b;
      endcase
    end else if (op == 7'h63) begin
      case (f3)
        3'd0, 3'd1: begin
          s = longint'($signed(a)) - longint'($signed(b));
          e.result = s[31:0];
          e.ovf = ovf32(s);
          e.taken = (f3 == 3'd0) ? (a == b) : (a != b);
        end
        3'd4: begin e.result = 32'(lt);  e.taken = lt;   end
        3'd5: begin e.result = 32'(lt);  e.taken = !lt;  end
        3'd6: begin e.result = 32'(ltu); e.taken = ltu;  end
        3'd7: begin e.result = 32'(ltu); e.taken = !ltu; end
        default: legal = 1'b0;
      endcase
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      e.result = '0; e.taken = 1'b0; e.ovf = 1'b0; e.illegal = 1'b1;
    end
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Drive one instruction (call ~1 time unit after a rising edge); push expected on accept.
  task automatic issue(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                       logic [31:0] a, logic [31:0] rs2, logic [31:0] imm, logic [4:0] tag, exp_t e);
    bit done = 0;
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rs1 = a; in_rs2 = rs2; in_imm = imm; in_tag = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        if (e.illegal && ill_model < 255) ill_model++;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue_m(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                         logic [31:0] a, logic [31:0] rs2, logic [31:0] imm, logic [4:0] tag);
    issue(op, f3, f7, a, rs2, imm, tag, model(op, f3, f7, a, rs2, imm, tag));
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops on every consuming edge and checks hold-stability under backpressure.
  task automatic monitor();
    exp_t snap, e, c;
    bit   hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
      end else begin
        c = cur_out();
        if (hold) begin
          n_checks++;
          if (!out_valid || c !== snap) begin
            n_fail++;
            $display("FAIL hold_stable: got v=%0b %h required v=1 %h", out_valid, c, snap);
          end
        end
        if (out_valid && out_ready) begin
          hold = 0;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got %h required none", c);
          end else begin
            e = sb.pop_front();
            if (c !== e) begin
              n_fail++;
              $display("FAIL output tag=%0d: got res=%h tk=%b br=%b ov=%b z=%b il=%b tag=%0d required res=%h tk=%b br=%b ov=%b z=%b il=%b tag=%0d",
                       e.tag, c.result, c.taken, c.is_branch, c.ovf, c.zero, c.illegal, c.tag,
                       e.result, e.taken, e.is_branch, e.ovf, e.zero, e.illegal, e.tag);
            end
          end
        end else if (out_valid) begin
          hold = 1;
          snap = c;
        end else begin
          hold = 0;
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b2, imm, rnd;
    int          r;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_tag = '0;
    bp_done = 1'b0;
    fork
      monitor();
      ready_drv();
    join_none

    #12;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(out_result), 64'd0);
    chk("reset_illegal_count", 64'(illegal_count), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD overflow, with 2-cycle latency check
    issue(7'h33, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd1, mk(32'h8000_0000, 0, 0, 1, 0, 0, 5'd1));
    @(posedge clk); #1;
    chk("latency_valid", 64'(out_valid), 64'd1);
    chk("latency_result", 64'(out_result), 64'h8000_0000);
    issue(7'h33, 3'd0, 7'h20, 32'd5, 32'd5, 32'd0, 5'd2, mk(32'd0, 0, 0, 0, 1, 0, 5'd2));
    issue(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'h405, 5'd3, mk(32'hFC00_0000, 0, 0, 0, 0, 0, 5'd3));
    issue(7'h63, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd4, mk(32'd1, 1, 1, 0, 0, 0, 5'd4));
    issue(7'h63, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd5, mk(32'd0, 0, 1, 0, 1, 0, 5'd5));
    issue(7'h63, 3'd1, 7'h00, 32'd7, 32'd7, 32'd0, 5'd6, mk(32'd0, 0, 1, 0, 1, 0, 5'd6));
    issue(7'h37, 3'd0, 7'h00, 32'd9, 32'd9, 32'd9, 5'd7, mk(32'd0, 0, 0, 0, 1, 1, 5'd7));
    issue(7'h33, 3'd0, 7'h01, 32'd9, 32'd9, 32'd0, 5'd8, mk(32'd0, 0, 0, 0, 1, 1, 5'd8));
    drain();
    chk("illegal_count_two", 64'(illegal_count), 64'd2);

    // Randomized traffic with random backpressure
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      rnd = $urandom;
      op = (r < 4) ? 7'h33 : (r < 7) ? 7'h13 : (r < 9) ? 7'h63 : rnd[6:0];
      f3 = rnd[9:7];
      r = $urandom_range(0, 5);
      f7 = (r < 3) ? 7'h00 : (r < 5) ? 7'h20 : rnd[16:10];
      a = pick();
      b2 = ($urandom_range(0, 3) == 0) ? a : pick();
      imm = {{20{f7[6]}}, f7, rnd[21:17]};
      issue_m(op, f3, f7, a, b2, imm, 5'(i));
    end
    rdy_mode = 1;
    drain();
    chk("illegal_count_random", 64'(illegal_count), 64'(ill_model));

    // Saturation
    for (int i = 0; i < 300; i++) issue_m(7'h37, 3'd0, 7'h00, $urandom, $urandom, $urandom, 5'(i));
    drain();
    chk("illegal_count_sat", 64'(illegal_count), 64'd255);

    // Backpressure: 4 tagged instructions with out_ready held low
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    fork
      begin
        for (int t = 0; t < 4; t++) issue_m(7'h33, 3'd0, 7'h00, 32'(t * 10), 32'd3, 32'd0, 5'(t));
        bp_done = 1'b1;
      end
    join_none
    repeat (8) @(posedge clk);
    #2;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_out_tag", 64'(out_tag), 64'd0);
    chk("bp_accepted", 64'(sb.size()), 64'd2);
    rdy_mode = 1;
    for (int i = 0; i < 200 && !bp_done; i++) @(posedge clk);
    if (!bp_done) chk("bp_timeout", 64'd0, 64'd1);
    drain();

    // Asynchronous reset with both stages full
    @(posedge clk); #1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    issue_m(7'h37, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 5'd20);
    issue_m(7'h33, 3'd0, 7'h00, 32'd1, 32'd2, 32'd3, 5'd21);
    #2;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_count", 64'(illegal_count), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    ill_model = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rdy_mode = 1;
    repeat (6) @(posedge clk);
    #2;
    chk("post_reset_valid", 64'(out_valid), 64'd0);
    issue_m(7'h33, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 5'd22);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage execute front end for the existing `alu`. It accepts RV32I register-register, register-immediate and branch instructions over a valid/ready handshake and decodes `opcode`/`funct3`/`funct7` into `alu_control_t`. It drives the ALU from a registered issue stage, then registers the result, flags and branch decision into an output stage with its own valid/ready handshake. It sits between the register-read stage and writeback/PC-redirect logic. It is the decoding producer of the ALU's control and operand inputs.

## Interface
- `N`, 32: datapath width. Only 32 is supported.
- `TAG_W`, 5: width of the pass-through tag (destination register index).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- `in_valid` input 1: upstream presents an instruction.
- `in_ready` output 1: the block accepts the instruction on this edge.
- `in_opcode` input 7: instruction bits [6:0].
- `in_funct3` input 3: instruction bits [14:12].
- `in_funct7` input 7: instruction bits [31:25].
- `in_rs1` input N: rs1 value.
- `in_rs2` input N: rs2 value.
- `in_imm` input N: immediate, already sign-extended by upstream.
- `in_tag` input TAG_W: opaque tag, passed through unchanged.
- `out_valid` output 1: output stage holds a completed instruction.
- `out_ready` input 1: downstream consumes the output on this edge.
- `out_result` output N: ALU result. Forced to 0 for illegal instructions.
- `out_taken` output 1: branch resolved taken. 0 for non-branches.
- `out_is_branch` output 1: the instruction was a BRANCH.
- `out_overflow`, `out_zero` output 1 each: ALU flags for this instruction.
- `out_illegal` output 1: the instruction was not decodable.
- `out_tag` output TAG_W: tag of this instruction.
- `illegal_count` output 8: saturating count of illegal instructions that reached the output stage.

## Operation
- Decode happens on acceptance; stage 1 (S1) registers the decoded `alu_control_t`, operand a, operand b, tag, is_branch, illegal and branch funct3.
- Operand a is always `in_rs1`.
- OP (0110011): operand b = `in_rs2`. funct3 decode:
  - 000: ADD when funct7[5]=0, SUB when funct7[5]=1.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRL when funct7[5]=0, SRA when funct7[5]=1.
  - 110: OR. 111: AND.
  - funct7 values other than 0000000/0100000 are illegal. 0100000 is legal only with funct3 000 or 101.
- OP-IMM (0010011): operand b = `in_imm`.
  - Same funct3 mapping as OP, except 000 is always ADD.
  - For 001/101, funct7 is imm[11:5] under the same legality rule. Only 101 may carry 0100000 (SRAI).
- BRANCH (1100011): operand b = `in_rs2`.
  - BEQ (000) and BNE (001) use SUB; taken = `equal` or `~equal` respectively.
  - BLT (100) and BGE (101) use SLT; taken = result[0] or `~result[0]`.
  - BLTU (110) and BGEU (111) use SLTU; taken = result[0] or `~result[0]`.
  - funct3 010 and 011 are illegal.
  - `out_result` carries the raw ALU result.
- Any other opcode is illegal. Illegal instructions still flow through the pipeline in order: control=ALU_ADD, result=0, taken=0, overflow=0, zero=1.
- Output stage (S2) registers the ALU outputs computed combinationally from S1.
- `illegal_count` increments on each S1→S2 transfer with illegal=1 and saturates at 255.

## Timing
- Reset (asynchronous, while `rst_n`=0): S1 valid=0, `out_valid`=0. All S2 outputs are 0, `illegal_count`=0, and S1 data registers are 0.
- `in_ready` = ~S1.valid | S2_advance, where S2_advance = ~`out_valid` | `out_ready`. `in_ready` is purely combinational and does not depend on `in_valid`.
- Accept on an edge where `in_valid` & `in_ready`. S1→S2 transfer on an edge where S1.valid & S2_advance.
- Latency is 2 cycles: an instruction accepted at edge k shows `out_valid`=1 after edge k+1.
- Throughput is 1 instruction per cycle while `out_ready`=1.
- Backpressure: with `out_ready`=0 and both stages full, `in_ready`=0. All outputs hold stable until consumed.
- Simultaneous accept and S1→S2 transfer in the same cycle is legal, and no bubble is inserted.
- `out_*` changes only on a consuming edge or when `out_valid` was 0.
- Reset asserted mid-operation discards both stages immediately. There is no partial output.

## Test plan
- Reset, then issue OP ADD with rs1=0x7FFFFFFF, rs2=1 → 2 cycles later: result=0x80000000, overflow=1, zero=0, illegal=0.
- OP SUB with funct7=0x20, rs1=5, rs2=5, followed back-to-back by OP-IMM SRAI (funct3=101, imm=0x405), rs1=0x80000000 → consecutive cycles: result=0 with zero=1, then result=0xFC000000.
- BRANCH BLT with rs1=0xFFFFFFFF, rs2=1 → taken=1, is_branch=1. Same operands with BLTU → taken=0. BNE with equal operands → taken=0.
- Issue opcode 0x37, then OP with funct7=0x01 → both illegal=1, result=0, tag preserved, `illegal_count`=2. Push 300 illegal instructions → `illegal_count`=255.
- Stream 4 tagged instructions with `out_ready` held 0 → after 2 accepts `in_ready`=0 and outputs stay stable. Release `out_ready` → tags emerge 0,1,2,3 in order with no loss or duplication.
- Assert `rst_n`=0 asynchronously with both stages full → `out_valid` drops before the next clock edge, and no stale output appears after release.
